// File: rtl/fw_pkg.sv
// fw_pkg: shared definitions for the frame-buffer write front end.
//   - Screen geometry and address widths
//   - FSM state encoding
//   - Queue entry layout {addr, color}
//   - pix_offset(): linear pixel offset y*640 + x, built from shifts and adds
package fw_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int ADDR_W   = 20;
  localparam int OFFS_W   = 19;
  localparam int COLOR_W  = 3;
  localparam int X_W      = 10;
  localparam int Y_W      = 9;

  typedef enum logic [1:0] {
    ST_DRAW       = 2'd0,
    ST_DRAIN      = 2'd1,
    ST_WAIT_VSYNC = 2'd2
  } fw_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] color;
  } pix_entry_t;

  localparam int ENTRY_W = $bits(pix_entry_t);

  // y*640 = y*512 + y*128; the largest on-screen offset (307199) fits in 19 bits.
  function automatic logic [OFFS_W-1:0] pix_offset(input logic [Y_W-1:0] y,
                                                   input logic [X_W-1:0] x);
    logic [OFFS_W-1:0] y_ext;
    y_ext = OFFS_W'(y);
    return (y_ext << 9) + (y_ext << 7) + OFFS_W'(x);
  endfunction

endpackage

// File: rtl/fw_fifo.sv
// fw_fifo: synchronous FIFO with registered storage.
//   clk, rst  : clock, synchronous active-low reset (clears pointers only)
//   i_push    : write i_data (taken when not full, or when full and popping)
//   i_pop     : discard the head entry (ignored when empty)
//   o_data    : head entry, valid while o_empty is low
//   o_full    : DEPTH entries held
//   o_empty   : no entries held
module fw_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = r_mem[r_rd_ptr[PTR_W-1:0]];

  // NOTE: storage is deliberately not reset; empty pointers already mark every
  // entry invalid, and leaving the array reset-free lets it map to plain RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + {{PTR_W{1'b0}}, 1'b1};
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{PTR_W{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/frame_writer.sv
// frame_writer: frame-buffer write front end.
//   clk, rst                  : clock, synchronous active-low reset
//   pix_valid/pix_ready       : pixel handshake from the line generator
//   pix_x, pix_y, pix_color   : pixel coordinates and colour
//   raster_done               : frame fully rasterised (pulse)
//   vsync                     : display vertical blank start (pulse)
//   mem_we/mem_ready          : write handshake to the pixel memory
//   mem_addr, mem_data        : {back bank, offset} and colour of the queue head
//   disp_bank                 : bank currently scanned out (front)
//   swapped                   : one-cycle pulse when disp_bank toggles
// Off-screen pixels complete their handshake but are never written.
module frame_writer
  import fw_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_valid,
  input  logic [X_W-1:0]     pix_x,
  input  logic [Y_W-1:0]     pix_y,
  input  logic [COLOR_W-1:0] pix_color,
  output logic               pix_ready,
  input  logic               raster_done,
  input  logic               vsync,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_data,
  input  logic               mem_ready,
  output logic               disp_bank,
  output logic               swapped
);

  fw_state_e  r_state;
  fw_state_e  w_next_state;
  logic       r_disp_bank;
  logic       w_next_bank;
  logic       r_swapped;
  logic       w_next_swapped;
  logic       w_pix_ready;
  logic       w_in_range;
  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  pix_entry_t w_entry_in;
  pix_entry_t w_head;

  assign w_in_range       = (pix_x < X_W'(SCREEN_W)) && (pix_y < Y_W'(SCREEN_H));
  // Address is captured at accept time, so a later swap never retargets it.
  assign w_entry_in.addr  = {~r_disp_bank, pix_offset(pix_y, pix_x)};
  assign w_entry_in.color = pix_color;
  assign w_push           = pix_valid & w_pix_ready & w_in_range;
  assign w_pop            = ~w_empty & mem_ready;

  fw_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_entry_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign mem_we    = ~w_empty;
  assign mem_addr  = w_head.addr;
  assign mem_data  = w_head.color;
  assign pix_ready = w_pix_ready;
  assign disp_bank = r_disp_bank;
  assign swapped   = r_swapped;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_DRAW;
      r_disp_bank <= 1'b0;
      r_swapped   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_disp_bank <= w_next_bank;
      r_swapped   <= w_next_swapped;
    end
  end

  // NOTE: every output of this block is defaulted first so no path through the
  // case leaves a signal unassigned, which would infer a latch.
  always_comb begin
    w_next_state   = r_state;
    w_next_bank    = r_disp_bank;
    w_next_swapped = 1'b0;
    w_pix_ready    = 1'b0;
    unique case (r_state)
      ST_DRAW: begin
        w_pix_ready = ~w_full;
        if (raster_done) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        // vsync is ignored here: the back bank is not complete yet.
        if (w_empty) w_next_state = ST_WAIT_VSYNC;
      end
      ST_WAIT_VSYNC: begin
        if (vsync) begin
          w_next_bank    = ~r_disp_bank;
          w_next_swapped = 1'b1;
          w_next_state   = ST_DRAW;
        end
      end
      default: w_next_state = ST_DRAW;
    endcase
  end

endmodule

// File: tb/tb_frame_writer.sv
// tb_frame_writer: directed and randomized checks of frame_writer against a
// transaction-level model (write queue, frame phase, display bank).
module tb_frame_writer;

  localparam int DEPTH = 4;
  localparam int PH_DRAW  = 0;
  localparam int PH_DRAIN = 1;
  localparam int PH_WAIT  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pix_valid = 1'b0;
  logic [9:0]  pix_x = '0;
  logic [8:0]  pix_y = '0;
  logic [2:0]  pix_color = '0;
  logic        pix_ready;
  logic        raster_done = 1'b0;
  logic        vsync = 1'b0;
  logic        mem_we;
  logic [19:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_ready = 1'b1;
  logic        disp_bank;
  logic        swapped;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [22:0] m_q[$];
  int          m_phase;
  logic        m_bank;
  logic        m_swapped;
  bit          m_valid = 1'b0;
  bit          last_acc;

  frame_writer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_valid   (pix_valid),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_color   (pix_color),
    .pix_ready   (pix_ready),
    .raster_done (raster_done),
    .vsync       (vsync),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .disp_bank   (disp_bank),
    .swapped     (swapped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare outputs against the model, then advance one clock and update it.
  task automatic tick();
    bit   e_ready;
    bit   acc;
    bit   inr;
    int   pre_size;
    logic [18:0] off;
    pre_size = m_q.size();
    e_ready  = (m_phase == PH_DRAW) && (pre_size < DEPTH);
    if (m_valid) begin
      chk("pix_ready", 32'(pix_ready), 32'(e_ready));
      chk("mem_we", 32'(mem_we), 32'(pre_size > 0));
      if (pre_size > 0) begin
        chk("mem_addr", 32'(mem_addr), 32'(m_q[0][22:3]));
        chk("mem_data", 32'(mem_data), 32'(m_q[0][2:0]));
      end
      chk("disp_bank", 32'(disp_bank), 32'(m_bank));
      chk("swapped", 32'(swapped), 32'(m_swapped));
    end
    acc = pix_valid && e_ready;
    inr = (int'(pix_x) < 640) && (int'(pix_y) < 480);
    off = 19'(int'(pix_y) * 640 + int'(pix_x));
    @(posedge clk);
    #1;
    if (!rst) begin
      m_q.delete();
      m_phase   = PH_DRAW;
      m_bank    = 1'b0;
      m_swapped = 1'b0;
      m_valid   = 1'b1;
      last_acc  = 1'b0;
    end else begin
      m_swapped = 1'b0;
      if (pre_size > 0 && mem_ready) void'(m_q.pop_front());
      if (acc && inr) m_q.push_back({~m_bank, off, pix_color});
      case (m_phase)
        PH_DRAW:  if (raster_done) m_phase = PH_DRAIN;
        PH_DRAIN: if (pre_size == 0) m_phase = PH_WAIT;
        default:  if (vsync) begin
                    m_bank    = ~m_bank;
                    m_swapped = 1'b1;
                    m_phase   = PH_DRAW;
                  end
      endcase
      last_acc = acc;
    end
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0; raster_done = 1'b0; vsync = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pixel(input int x, input int y, input int c);
    pix_valid = 1'b1; pix_x = 10'(x); pix_y = 9'(y); pix_color = 3'(c);
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic pulse_rd(input bit with_vsync);
    raster_done = 1'b1; vsync = with_vsync;
    tick();
    raster_done = 1'b0; vsync = 1'b0;
  endtask

  task automatic pulse_vs();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
  endtask

  initial begin
    int k;
    // Reset
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    chk("rst_ready", 32'(pix_ready), 32'd1);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_bank", 32'(disp_bank), 32'd0);
    chk("rst_swapped", 32'(swapped), 32'd0);

    // Single on-screen pixel, one cycle to the write
    mem_ready = 1'b1;
    pixel(5, 2, 5);
    chk("t1_we", 32'(mem_we), 32'd1);
    chk("t1_addr", 32'(mem_addr), 32'h80505);
    chk("t1_data", 32'(mem_data), 32'd5);
    idle(1);
    chk("t1_single", 32'(mem_we), 32'd0);

    // Off-screen pixels: handshake completes, nothing written
    pixel(640, 0, 1);
    chk("t2_acc_x", 32'(last_acc), 32'd1);
    pixel(0, 480, 2);
    chk("t2_acc_y", 32'(last_acc), 32'd1);
    idle(2);

    // Backpressure: queue fills, then drains in order
    mem_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 8 && k < 6; c++) begin
      pix_valid = 1'b1; pix_x = 10'(20 + k); pix_y = 9'd3; pix_color = 3'(k);
      tick();
      if (last_acc) k++;
    end
    chk("t3_accepts", 32'(k), 32'd4);
    chk("t3_stall", 32'(pix_ready), 32'd0);
    mem_ready = 1'b1;
    for (int c = 0; c < 20 && k < 6; c++) begin
      pix_valid = 1'b1; pix_x = 10'(20 + k); pix_y = 9'd3; pix_color = 3'(k);
      tick();
      if (last_acc) k++;
    end
    chk("t3_all", 32'(k), 32'd6);
    idle(8);

    // Drain with vsync ignored, then swap on a later vsync
    mem_ready = 1'b0;
    pixel(1, 1, 3);
    pixel(2, 1, 4);
    pulse_rd(1'b0);
    pulse_vs();
    idle(2);
    chk("t4_noswap", 32'(disp_bank), 32'd0);
    mem_ready = 1'b1;
    idle(4);
    pulse_vs();
    chk("t4_bank", 32'(disp_bank), 32'd1);
    chk("t4_pulse", 32'(swapped), 32'd1);
    pixel(7, 0, 6);
    chk("t4_addr", 32'(mem_addr), 32'h00007);
    idle(3);

    // raster_done and vsync together: vsync is not a swap trigger yet
    pulse_rd(1'b1);
    idle(3);
    chk("t5_noswap", 32'(disp_bank), 32'd1);
    pulse_vs();
    chk("t5_bank", 32'(disp_bank), 32'd0);
    idle(1);

    // Reset while waiting for vsync with disp_bank=1
    pulse_rd(1'b0);
    idle(2);
    pulse_vs();
    pulse_rd(1'b0);
    idle(2);
    chk("t6_pre_bank", 32'(disp_bank), 32'd1);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    chk("t6_bank", 32'(disp_bank), 32'd0);
    chk("t6_we", 32'(mem_we), 32'd0);
    chk("t6_ready", 32'(pix_ready), 32'd1);
    chk("t6_swapped", 32'(swapped), 32'd0);
    idle(2);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      pix_valid   = 1'($urandom_range(0, 1));
      pix_x       = ($urandom % 8 == 0) ? 10'($urandom_range(640, 1023)) : 10'($urandom_range(0, 639));
      pix_y       = ($urandom % 8 == 0) ? 9'($urandom_range(480, 511))   : 9'($urandom_range(0, 479));
      pix_color   = 3'($urandom);
      mem_ready   = ($urandom % 4) != 0;
      raster_done = ($urandom % 25) == 0;
      vsync       = ($urandom % 6) == 0;
      rst         = ($urandom % 250) != 0;
      tick();
    end
    rst = 1'b1;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
